lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the data-memory access block; sits between EXU and the raw memory port.
- Accepts one load/store request per valid/ready handshake and checks alignment and funct3.
- Drives the byte-masked memory access, waits a parameterised latency, then extracts and sign/zero-extends load data.
- Returns the result to WBU through a valid/ready handshake.

Parameters:
- MEM_LATENCY, 1, cycles the ACCESS state lasts (>=1); mem_rdata sampled at end of last ACCESS cycle.
- XLEN, 64, data/address width; only 64 supported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_is_store  in  1  1=store, 0=load.
- req_funct3  in  3  RV64 load/store funct3.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, LSB-justified.
- req_rd  in  5  load destination register, passed through.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  64  extended load data; 0 for stores and faults.
- resp_rd  out  5  captured req_rd.
- resp_fault  out  1  misaligned address or illegal funct3.
- mem_addr  out  64  req_addr with bits [2:0] cleared.
- mem_read_en  out  1  read strobe.
- mem_write_en  out  1  write strobe.
- mem_wmask  out  8  byte-lane write mask.
- mem_write_data  out  64  lane-shifted store data.
- mem_rdata  in  64  raw 8-byte-aligned read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE. All mem_* outputs, resp_valid, resp_data, resp_rd and resp_fault are 0.
- req_ready=(state==IDLE), so it reads 1 after reset. No request is captured while reset is low.
- Reset asserted mid-operation: return to IDLE immediately and drop strobes the same instant. An in-flight store is not guaranteed to be written; no response is produced.
- IDLE:
  - On req_valid&&req_ready, register is_store, funct3, addr, wdata and rd.
  - Fault if: load funct3=111; store funct3>=100; half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
  - Fault -> RESP with resp_fault=1, resp_data=0. No memory strobe is ever asserted for a faulting request.
  - Otherwise -> ACCESS and load the counter with MEM_LATENCY-1.
- ACCESS:
  - mem_addr, mem_wmask and mem_write_data are held stable for all ACCESS cycles.
  - mem_read_en=1 in every ACCESS cycle of a load.
  - mem_write_en=1 only in the first ACCESS cycle of a store.
  - Counter decrements each cycle. When it is 0, latch the extended load result (stores: 0) and go to RESP.
- RESP: resp_valid=1 with stable data until resp_ready; on handshake go to IDLE. There is no back-to-back bypass; accept-to-accept throughput is MEM_LATENCY+2 cycles minimum.
- Latency: handshake in cycle 0, ACCESS in cycles 1..MEM_LATENCY, resp_valid from cycle MEM_LATENCY+1.
- Store lanes, with off=addr[2:0]:
  - wmask: SB=0x01<<off, SH=0x03<<off, SW=0x0F<<off, SD=0xFF.
  - write_data = wdata<<(8*off), truncated to 64 bits.
- Load extract: shifted = mem_rdata>>(8*off).
  - LB/LH/LW sign-extend bits 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD passes all 64 bits.
- All strobes and mem_wmask are 0 outside ACCESS.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (LB..LWU, SB..SD);
  - FSM state encoding;
  - size/alignment-check helper function.
- One natural sub-module, lsu_align: purely combinational store mask/shift and load extract/extend, instantiated once in lsu_ctrl.

Test Plan:
- SW at addr=0x8000_0004, wdata=0xDEADBEEF, MEM_LATENCY=1 -> cycle 1: mem_write_en=1, mem_addr=0x8000_0000, mem_wmask=0xF0, mem_write_data=0xDEADBEEF_00000000; cycle 2: resp_valid=1, resp_fault=0, resp_data=0.
- LB at off=3, mem_rdata=0x0000_0000_8000_0000 -> resp_data=0xFFFF_FFFF_FFFF_FF80. LBU at the same off and data -> resp_data=0x80.
- LH at addr=0x8000_0001 -> resp_fault=1, resp_data=0; mem_read_en and mem_write_en never asserted; resp_valid in cycle 1.
- MEM_LATENCY=3, LD -> mem_read_en high for cycles 1-3; resp_valid in cycle 4; resp_data equals mem_rdata sampled at end of cycle 3.
- resp_ready held 0 for 5 cycles -> resp_valid, resp_data and resp_rd stay stable; req_ready=0 throughout; new request accepted the cycle after the handshake.
- reset pulled low in the ACCESS cycle of an SD -> mem_write_en and resp_valid drop to 0 asynchronously; after release, req_ready=1 and no response is emitted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 codes, FSM encoding and the fault check.
package lsu_pkg;

  localparam int unsigned DATA_W = 64;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic req_fault(input logic is_store, input logic [2:0] funct3,
                                     input logic [2:0] off);
    logic bad_f3;
    logic misaligned;
    bad_f3 = is_store ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
    return bad_f3 | misaligned;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: store mask/shift and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [2:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [7:0]        st_mask,
  output logic [DATA_W-1:0] st_lanes,
  input  logic [2:0]        ld_funct3,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_shifted;

  always_comb begin
    st_mask = 8'h00;
    case (st_size)
      2'b00:   st_mask = 8'h01 << st_off;
      2'b01:   st_mask = 8'h03 << st_off;
      2'b10:   st_mask = 8'h0F << st_off;
      default: st_mask = 8'hFF;
    endcase
    st_lanes = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_shifted = ld_raw >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LW:   ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      F3_LBU:  ld_data = {56'd0, ld_shifted[7:0]};
      F3_LHU:  ld_data = {48'd0, ld_shifted[15:0]};
      F3_LWU:  ld_data = {32'd0, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: request check, timed memory access, load extend, response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [7:0]      mem_wmask,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [2:0]       off_q, off_d;

  logic            req_ready_d, resp_valid_d, resp_fault_d;
  logic [XLEN-1:0] resp_data_d, mem_addr_d, mem_write_data_d;
  logic [4:0]      resp_rd_d;
  logic            mem_read_en_d, mem_write_en_d;
  logic [7:0]      mem_wmask_d;

  logic [7:0]      st_mask;
  logic [XLEN-1:0] st_lanes, ld_data;

  lsu_align u_align (
    .st_size   (req_funct3[1:0]),
    .st_off    (req_addr[2:0]),
    .st_data   (req_wdata),
    .st_mask   (st_mask),
    .st_lanes  (st_lanes),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_raw    (mem_rdata),
    .ld_data   (ld_data)
  );

  // Next state and next registered outputs; strobes and mask default low.
  always_comb begin
    state_d          = state;
    cnt_d            = cnt;
    is_store_d       = is_store_q;
    funct3_d         = funct3_q;
    off_d            = off_q;
    req_ready_d      = req_ready;
    resp_valid_d     = resp_valid;
    resp_data_d      = resp_data;
    resp_rd_d        = resp_rd;
    resp_fault_d     = resp_fault;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    mem_read_en_d    = 1'b0;
    mem_write_en_d   = 1'b0;
    mem_wmask_d      = 8'h00;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d  = req_is_store;
          funct3_d    = req_funct3;
          off_d       = req_addr[2:0];
          resp_rd_d   = req_rd;
          req_ready_d = 1'b0;
          if (req_fault(req_is_store, req_funct3, req_addr[2:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d          = ST_ACCESS;
            cnt_d            = CNT_W'(MEM_LATENCY - 1);
            mem_addr_d       = {req_addr[XLEN-1:3], 3'b000};
            mem_read_en_d    = ~req_is_store;
            mem_write_en_d   = req_is_store;
            mem_wmask_d      = req_is_store ? st_mask : 8'h00;
            mem_write_data_d = req_is_store ? st_lanes : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_data_d  = is_store_q ? '0 : ld_data;
        end else begin
          cnt_d         = cnt - CNT_W'(1);
          mem_read_en_d = ~is_store_q;
          mem_wmask_d   = mem_wmask;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'd0;
      off_q          <= 3'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_rd        <= 5'd0;
      resp_fault     <= 1'b0;
      mem_addr       <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_wmask      <= 8'h00;
      mem_write_data <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_data      <= resp_data_d;
      resp_rd        <= resp_rd_d;
      resp_fault     <= resp_fault_d;
      mem_addr       <= mem_addr_d;
      mem_read_en    <= mem_read_en_d;
      mem_write_en   <= mem_write_en_d;
      mem_wmask      <= mem_wmask_d;
      mem_write_data <= mem_write_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboarded bench for lsu_ctrl at MEM_LATENCY=1 (dut) and MEM_LATENCY=3 (dut3).
module tb_lsu_ctrl;
  import lsu_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rdata;
    logic [63:0] exp;
    logic [7:0]  mask;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_is_store, resp_valid, resp_ready, resp_fault;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata, resp_data, mem_addr, mem_write_data, mem_rdata;
  logic [4:0]  req_rd, resp_rd;
  logic        mem_read_en, mem_write_en;
  logic [7:0]  mem_wmask;

  logic        req_valid3, req_ready3, req_is_store3, resp_valid3, resp_ready3, resp_fault3;
  logic [2:0]  req_funct3_3;
  logic [63:0] req_addr3, req_wdata3, resp_data3, mem_addr3, mem_write_data3, mem_rdata3;
  logic [4:0]  req_rd3, resp_rd3;
  logic        mem_read_en3, mem_write_en3;
  logic [7:0]  mem_wmask3;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  lsu_ctrl #(.MEM_LATENCY(1), .XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wmask(mem_wmask), .mem_write_data(mem_write_data), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.MEM_LATENCY(3), .XLEN(64)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_is_store(req_is_store3),
    .req_funct3(req_funct3_3), .req_addr(req_addr3), .req_wdata(req_wdata3), .req_rd(req_rd3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
    .resp_rd(resp_rd3), .resp_fault(resp_fault3),
    .mem_addr(mem_addr3), .mem_read_en(mem_read_en3), .mem_write_en(mem_write_en3),
    .mem_wmask(mem_wmask3), .mem_write_data(mem_write_data3), .mem_rdata(mem_rdata3)
  );

  task automatic send(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
  endtask

  // Every task starts and ends at a falling edge with dut idle.
  task automatic test_reset();
    reset = 1'b0;
    send(1'b0, F3_LD, 64'h40, 64'h0, 5'd7);
    repeat (3) @(negedge clock);
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else pass_cnt++;
    chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
    chk_cnt++; if ({mem_read_en, mem_write_en, mem_wmask} !== 10'd0) $display("FAIL rst_strobes: got %b%b %h want 0", mem_read_en, mem_write_en, mem_wmask); else pass_cnt++;
    chk_cnt++; if ({mem_addr, mem_write_data} !== 128'd0) $display("FAIL rst_mem_bus: got %h %h want 0", mem_addr, mem_write_data); else pass_cnt++;
    chk_cnt++; if ({resp_data, resp_rd, resp_fault} !== 70'd0) $display("FAIL rst_resp: got %h %0d %b want 0", resp_data, resp_rd, resp_fault); else pass_cnt++;
    chk_cnt++; if (req_ready3 !== 1'b1) $display("FAIL rst_req_ready3: got %b want 1", req_ready3); else pass_cnt++;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk_cnt++; if (req_ready !== 1'b1 || mem_read_en !== 1'b0) $display("FAIL rst_no_capture: ready %b rd_en %b want 1 0", req_ready, mem_read_en); else pass_cnt++;
  endtask

  task automatic test_store_lanes();
    vec_t v[5];
    exp_t e;
    v[0] = '{1'b1, F3_SW, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0};
    v[1] = '{1'b1, F3_SB, 64'h1000_0005, 64'h1122_3344_5566_7788, 64'h0, 64'h6677_8800_0000_0000, 8'h20};
    v[2] = '{1'b1, F3_SH, 64'h1000_0002, 64'h0000_0000_0000_1234, 64'h0, 64'h0000_0000_1234_0000, 8'h0C};
    v[3] = '{1'b1, F3_SD, 64'h1000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF};
    v[4] = '{1'b1, F3_SH, 64'h1000_0006, 64'hFFFF_FFFF_FFFF_A55A, 64'h0, 64'hA55A_0000_0000_0000, 8'hC0};
    for (int i = 0; i < 5; i++) begin
      send(v[i].st, v[i].f3, v[i].addr, v[i].wd, 5'(i + 1));
      sb.push_back('{data: 64'h0, rd: 5'(i + 1), fault: 1'b0});
      chk_cnt++; if (req_ready !== 1'b1) $display("FAIL st%0d_ready: got %b want 1", i, req_ready); else pass_cnt++;
      @(negedge clock);
      req_valid = 1'b0;
      chk_cnt++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) $display("FAIL st%0d_strobe: wr %b rd %b want 1 0", i, mem_write_en, mem_read_en); else pass_cnt++;
      chk_cnt++; if (mem_addr !== {v[i].addr[63:3], 3'b000}) $display("FAIL st%0d_addr: got %h want %h", i, mem_addr, {v[i].addr[63:3], 3'b000}); else pass_cnt++;
      chk_cnt++; if (mem_wmask !== v[i].mask) $display("FAIL st%0d_wmask: got %h want %h", i, mem_wmask, v[i].mask); else pass_cnt++;
      chk_cnt++; if (mem_write_data !== v[i].exp) $display("FAIL st%0d_wdata: got %h want %h", i, mem_write_data, v[i].exp); else pass_cnt++;
      @(negedge clock);
      chk_cnt++; if (mem_write_en !== 1'b0 || mem_wmask !== 8'h00) $display("FAIL st%0d_strobe_off: wr %b mask %h want 0", i, mem_write_en, mem_wmask); else pass_cnt++;
      chk_cnt++; if (resp_valid !== 1'b1) $display("FAIL st%0d_resp_valid: got %b want 1", i, resp_valid); else pass_cnt++;
      e = sb.pop_front();
      chk_cnt++; if ({resp_data, resp_rd, resp_fault} !== e) $display("FAIL st%0d_resp: got %h/%0d/%b want %h/%0d/%b", i, resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault); else pass_cnt++;
      @(negedge clock);
      chk_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL st%0d_idle: ready %b valid %b want 1 0", i, req_ready, resp_valid); else pass_cnt++;
    end
  endtask

  task automatic test_load_extend();
    vec_t v[10];
    exp_t e;
    v[0] = '{1'b0, F3_LB,  64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h0};
    v[1] = '{1'b0, F3_LBU, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h0};
    v[2] = '{1'b0, F3_LH,  64'h8000_0002, 64'h0, 64'hF1E2_D3C4_B5A6_9788, 64'hFFFF_FFFF_FFFF_B5A6, 8'h0};
    v[3] = '{1'b0, F3_LHU, 64'h8000_0006, 64'h0, 64'hF1E2_D3C4_B5A6_9788, 64'h0000_0000_0000_F1E2, 8'h0};
    v[4] = '{1'b0, F3_LW,  64'h8000_0004, 64'h0, 64'hF1E2_D3C4_B5A6_9788, 64'hFFFF_FFFF_F1E2_D3C4, 8'h0};
    v[5] = '{1'b0, F3_LWU, 64'h8000_0004, 64'h0, 64'hF1E2_D3C4_B5A6_9788, 64'h0000_0000_F1E2_D3C4, 8'h0};
    v[6] = '{1'b0, F3_LD,  64'h8000_0008, 64'h0, 64'hF1E2_D3C4_B5A6_9788, 64'hF1E2_D3C4_B5A6_9788, 8'h0};
    v[7] = '{1'b0, F3_LH,  64'h8000_0006, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0123, 8'h0};
    v[8] = '{1'b0, F3_LB,  64'h8000_0007, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001, 8'h0};
    v[9] = '{1'b0, F3_LW,  64'h8000_0000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_89AB_CDEF, 8'h0};
    for (int i = 0; i < 10; i++) begin
      send(v[i].st, v[i].f3, v[i].addr, 64'h0, 5'(i + 10));
      mem_rdata = v[i].rdata;
      sb.push_back('{data: v[i].exp, rd: 5'(i + 10), fault: 1'b0});
      @(negedge clock);
      req_valid = 1'b0;
      chk_cnt++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_wmask !== 8'h00) $display("FAIL ld%0d_strobe: rd %b wr %b mask %h want 1 0 00", i, mem_read_en, mem_write_en, mem_wmask); else pass_cnt++;
      chk_cnt++; if (mem_addr !== {v[i].addr[63:3], 3'b000}) $display("FAIL ld%0d_addr: got %h want %h", i, mem_addr, {v[i].addr[63:3], 3'b000}); else pass_cnt++;
      @(negedge clock);
      chk_cnt++; if (resp_valid !== 1'b1 || mem_read_en !== 1'b0) $display("FAIL ld%0d_resp_valid: valid %b rd %b want 1 0", i, resp_valid, mem_read_en); else pass_cnt++;
      e = sb.pop_front();
      chk_cnt++; if ({resp_data, resp_rd, resp_fault} !== e) $display("FAIL ld%0d_resp: got %h/%0d/%b want %h/%0d/%b", i, resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault); else pass_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic test_fault();
    vec_t v[8];
    exp_t e;
    v[0] = '{1'b0, F3_LH,  64'h8000_0001, 64'h0, 64'h0, 64'h0, 8'h0};
    v[1] = '{1'b0, F3_LW,  64'h8000_0002, 64'h0, 64'h0, 64'h0, 8'h0};
    v[2] = '{1'b0, F3_LD,  64'h8000_0004, 64'h0, 64'h0, 64'h0, 8'h0};
    v[3] = '{1'b0, F3_LHU, 64'h8000_0003, 64'h0, 64'h0, 64'h0, 8'h0};
    v[4] = '{1'b0, F3_LWU, 64'h8000_0006, 64'h0, 64'h0, 64'h0, 8'h0};
    v[5] = '{1'b0, 3'd7,   64'h8000_0000, 64'h0, 64'h0, 64'h0, 8'h0};
    v[6] = '{1'b1, 3'd4,   64'h8000_0000, 64'h5A, 64'h0, 64'h0, 8'h0};
    v[7] = '{1'b1, F3_SD,  64'h8000_0001, 64'h5A, 64'h0, 64'h0, 8'h0};
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      send(v[i].st, v[i].f3, v[i].addr, v[i].wd, 5'(i + 2));
      sb.push_back('{data: 64'h0, rd: 5'(i + 2), fault: 1'b1});
      @(negedge clock);
      req_valid = 1'b0;
      chk_cnt++; if (resp_valid !== 1'b1) $display("FAIL flt%0d_resp_valid: got %b want 1", i, resp_valid); else pass_cnt++;
      e = sb.pop_front();
      chk_cnt++; if ({resp_data, resp_rd, resp_fault} !== e) $display("FAIL flt%0d_resp: got %h/%0d/%b want %h/%0d/%b", i, resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault); else pass_cnt++;
      chk_cnt++; if ({mem_read_en, mem_write_en, mem_wmask} !== 10'd0) $display("FAIL flt%0d_strobe: rd %b wr %b mask %h want 0", i, mem_read_en, mem_write_en, mem_wmask); else pass_cnt++;
      @(negedge clock);
      chk_cnt++; if (req_ready !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) $display("FAIL flt%0d_idle: ready %b rd %b wr %b want 1 0 0", i, req_ready, mem_read_en, mem_write_en); else pass_cnt++;
    end
  endtask

  task automatic test_latency3();
    exp_t e;
    req_valid3 = 1'b1; req_is_store3 = 1'b0; req_funct3_3 = F3_LD;
    req_addr3 = 64'h1000_0008; req_wdata3 = 64'h0; req_rd3 = 5'd9;
    mem_rdata3 = 64'hAAAA_AAAA_AAAA_AAAA;
    sb.push_back('{data: 64'h1357_9BDF_2468_ACE0, rd: 5'd9, fault: 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      req_valid3 = 1'b0;
      if (c == 3) mem_rdata3 = 64'h1357_9BDF_2468_ACE0;
      chk_cnt++; if (mem_read_en3 !== 1'b1 || resp_valid3 !== 1'b0 || mem_wmask3 !== 8'h00) $display("FAIL l3_ld_c%0d: rd %b valid %b mask %h want 1 0 00", c, mem_read_en3, resp_valid3, mem_wmask3); else pass_cnt++;
      chk_cnt++; if (mem_addr3 !== 64'h1000_0008) $display("FAIL l3_ld_addr_c%0d: got %h want %h", c, mem_addr3, 64'h1000_0008); else pass_cnt++;
    end
    @(negedge clock);
    chk_cnt++; if (resp_valid3 !== 1'b1 || mem_read_en3 !== 1'b0) $display("FAIL l3_ld_resp_valid: valid %b rd %b want 1 0", resp_valid3, mem_read_en3); else pass_cnt++;
    e = sb.pop_front();
    chk_cnt++; if ({resp_data3, resp_rd3, resp_fault3} !== e) $display("FAIL l3_ld_resp: got %h/%0d/%b want %h/%0d/%b", resp_data3, resp_rd3, resp_fault3, e.data, e.rd, e.fault); else pass_cnt++;
    @(negedge clock);
    req_valid3 = 1'b1; req_is_store3 = 1'b1; req_funct3_3 = F3_SH;
    req_addr3 = 64'h1000_0012; req_wdata3 = 64'h0000_0000_0000_BEEF; req_rd3 = 5'd4;
    sb.push_back('{data: 64'h0, rd: 5'd4, fault: 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      req_valid3 = 1'b0;
      chk_cnt++; if (mem_write_en3 !== (c == 1) || mem_read_en3 !== 1'b0) $display("FAIL l3_st_wr_c%0d: wr %b rd %b want %b 0", c, mem_write_en3, mem_read_en3, (c == 1)); else pass_cnt++;
      chk_cnt++; if (mem_wmask3 !== 8'h0C || mem_write_data3 !== 64'h0000_0000_BEEF_0000) $display("FAIL l3_st_lanes_c%0d: mask %h data %h want 0c %h", c, mem_wmask3, mem_write_data3, 64'h0000_0000_BEEF_0000); else pass_cnt++;
    end
    @(negedge clock);
    chk_cnt++; if (resp_valid3 !== 1'b1 || mem_wmask3 !== 8'h00) $display("FAIL l3_st_resp_valid: valid %b mask %h want 1 00", resp_valid3, mem_wmask3); else pass_cnt++;
    e = sb.pop_front();
    chk_cnt++; if ({resp_data3, resp_rd3, resp_fault3} !== e) $display("FAIL l3_st_resp: got %h/%0d/%b want %h/%0d/%b", resp_data3, resp_rd3, resp_fault3, e.data, e.rd, e.fault); else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send(1'b0, F3_LW, 64'h2000_0004, 64'h0, 5'd21);
    mem_rdata = 64'h1234_5678_0000_0000;
    sb.push_back('{data: 64'h0000_0000_1234_5678, rd: 5'd21, fault: 1'b0});
    @(negedge clock);
    send(1'b0, F3_LD, 64'h3000_0000, 64'h0, 5'd22);
    sb.push_back('{data: 64'hCAFE_F00D_0BAD_BEEF, rd: 5'd22, fault: 1'b0});
    resp_ready = 1'b0;
    chk_cnt++; if (mem_read_en !== 1'b1 || mem_addr !== 64'h2000_0000) $display("FAIL bp_access: rd %b addr %h want 1 %h", mem_read_en, mem_addr, 64'h2000_0000); else pass_cnt++;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clock);
      chk_cnt++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL bp_hold_c%0d: valid %b ready %b want 1 0", c, resp_valid, req_ready); else pass_cnt++;
      chk_cnt++; if (resp_data !== 64'h0000_0000_1234_5678 || resp_rd !== 5'd21) $display("FAIL bp_stable_c%0d: got %h/%0d want %h/21", c, resp_data, resp_rd, 64'h0000_0000_1234_5678); else pass_cnt++;
    end
    @(negedge clock);
    resp_ready = 1'b1;
    e = sb.pop_front();
    chk_cnt++; if (resp_valid !== 1'b1 || {resp_data, resp_rd, resp_fault} !== e) $display("FAIL bp_resp: valid %b got %h/%0d/%b want %h/%0d/%b", resp_valid, resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault); else pass_cnt++;
    @(negedge clock);
    mem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    chk_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_reaccept: ready %b valid %b want 1 0", req_ready, resp_valid); else pass_cnt++;
    @(negedge clock);
    req_valid = 1'b0;
    chk_cnt++; if (mem_read_en !== 1'b1 || mem_addr !== 64'h3000_0000) $display("FAIL bp_second_access: rd %b addr %h want 1 %h", mem_read_en, mem_addr, 64'h3000_0000); else pass_cnt++;
    @(negedge clock);
    e = sb.pop_front();
    chk_cnt++; if (resp_valid !== 1'b1 || {resp_data, resp_rd, resp_fault} !== e) $display("FAIL bp_second_resp: valid %b got %h/%0d/%b want %h/%0d/%b", resp_valid, resp_data, resp_rd, resp_fault, e.data, e.rd, e.fault); else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    send(1'b1, F3_SD, 64'h4000_0008, 64'h0F0F_0F0F_0F0F_0F0F, 5'd30);
    @(negedge clock);
    req_valid = 1'b0;
    chk_cnt++; if (mem_write_en !== 1'b1) $display("FAIL mid_pre_write: got %b want 1", mem_write_en); else pass_cnt++;
    #1 reset = 1'b0;
    #1;
    chk_cnt++; if (mem_write_en !== 1'b0 || mem_wmask !== 8'h00 || resp_valid !== 1'b0) $display("FAIL mid_async_drop: wr %b mask %h valid %b want 0 00 0", mem_write_en, mem_wmask, resp_valid); else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_write_en !== 1'b0) $display("FAIL mid_after_c%0d: valid %b ready %b wr %b want 0 1 0", c, resp_valid, req_ready, mem_write_en); else pass_cnt++;
    end
  endtask

  initial begin
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    req_rd = 5'd0; resp_ready = 1'b1; mem_rdata = '0;
    req_valid3 = 1'b0; req_is_store3 = 1'b0; req_funct3_3 = 3'd0; req_addr3 = '0; req_wdata3 = '0;
    req_rd3 = 5'd0; resp_ready3 = 1'b1; mem_rdata3 = '0;
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_fault();
    test_latency3();
    test_back_to_back();
    test_reset_mid_op();
    chk_cnt++; if (sb.size() != 0) $display("FAIL sb_drained: %0d entries left want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
